// File: rtl/timer_int_source_if.sv
// Register bus between the CPU and the timer: word address, write strobe,
// write data, and combinational read data.
interface timer_int_source_if;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output addr, output we, output wdata, input rdata);
    modport slave  (input addr, input we, input wdata, output rdata);
endinterface

// File: rtl/timer_int_source.sv
// Programmable countdown timer driving one HWInt bit. It has one-shot and
// auto-reload modes, a sticky request flag, and an acknowledge clear.
module timer_int_source (
    input  logic                  clk,
    input  logic                  reset,
    timer_int_source_if.slave     bus,
    input  logic                  int_ack,
    output logic                  irq
);
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    state_t      state_reg, state_next;
    logic        en_reg, en_next;
    logic [1:0]  mode_reg, mode_next;
    logic        im_reg, im_next;
    logic [31:0] preset_reg, preset_next;
    logic [31:0] count_reg, count_next;
    logic        irq_flag_reg, irq_flag_next;
    logic        int_entry;

    logic ctrl_wr;
    logic preset_wr;
    logic auto_reload;

    assign ctrl_wr     = bus.we && (bus.addr == 2'd0);
    assign preset_wr   = bus.we && (bus.addr == 2'd1);
    // Only MODE 1 reloads; MODE 2 and MODE 3 fall back to one-shot.
    assign auto_reload = (mode_reg == 2'b01);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            en_reg       <= 1'b0;
            mode_reg     <= 2'b00;
            im_reg       <= 1'b0;
            preset_reg   <= 32'd0;
            count_reg    <= 32'd0;
            irq_flag_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            en_reg       <= en_next;
            mode_reg     <= mode_next;
            im_reg       <= im_next;
            preset_reg   <= preset_next;
            count_reg    <= count_next;
            irq_flag_reg <= irq_flag_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        en_next       = en_reg;
        mode_next     = mode_reg;
        im_next       = im_reg;
        preset_next   = preset_reg;
        count_next    = count_reg;
        irq_flag_next = irq_flag_reg;
        int_entry     = 1'b0;

        if (preset_wr) begin
            preset_next = bus.wdata;
        end

        case (state_reg)
            IDLE: begin
                if (en_reg) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                count_next = preset_reg;
                state_next = CNT;
            end
            CNT: begin
                if (!en_reg) begin
                    state_next = IDLE;
                end else if (count_reg > 32'd1) begin
                    count_next = count_reg - 32'd1;
                end else begin
                    // A zero preset also lands here, so COUNT never wraps.
                    count_next    = 32'd0;
                    irq_flag_next = 1'b1;
                    int_entry     = 1'b1;
                    state_next    = INT;
                end
            end
            INT: begin
                if (auto_reload) begin
                    irq_flag_next = 1'b0;
                    state_next    = LOAD;
                end else begin
                    en_next    = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // A new request outranks an acknowledge landing on the same edge.
        if (int_ack && !int_entry) begin
            irq_flag_next = 1'b0;
        end

        // A CTRL write restarts from IDLE, discards any pending request,
        // and freezes COUNT where it stood.
        if (ctrl_wr) begin
            en_next       = bus.wdata[0];
            mode_next     = bus.wdata[2:1];
            im_next       = bus.wdata[3];
            irq_flag_next = 1'b0;
            count_next    = count_reg;
            state_next    = IDLE;
        end
    end

    always_comb begin
        case (bus.addr)
            2'd0:    bus.rdata = {28'd0, im_reg, mode_reg, en_reg};
            2'd1:    bus.rdata = preset_reg;
            2'd2:    bus.rdata = count_reg;
            default: bus.rdata = 32'd0;
        endcase
    end

    assign irq = im_reg & irq_flag_reg;
endmodule

// File: tb/tb_timer_int_source.sv
// Directed bench for timer_int_source. Each task drives one scenario and
// checks the results inline against hand-computed values.
`timescale 1ns/1ps
module tb_timer_int_source;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic int_ack = 1'b0;
    logic irq;
    int   tests_run = 0;
    int   tests_failed = 0;
    int   edge_cnt = 0;
    logic [31:0] rv;

    timer_int_source_if bus();

    timer_int_source dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .int_ack (int_ack),
        .irq     (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt = edge_cnt + 1;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.addr  = a;
        bus.we    = 1'b1;
        bus.wdata = d;
        @(posedge clk);
        #1;
        bus.we   = 1'b0;
        bus.addr = 2'd0;
        $display("[TB] write addr=%0d data=0x%08h", a, d);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.addr = a;
        #1;
        d = bus.rdata;
        $display("[TB] read addr=%0d data=0x%08h", a, d);
    endtask

    task automatic test_reset();
        logic [1:0] a;
        bus.addr  = 2'd0;
        bus.we    = 1'b0;
        bus.wdata = 32'd0;
        reset     = 1'b0;
        tick(3);
        reset = 1'b1;
        #1;
        tests_run++;
        if (irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_irq got=%b exp=0", irq);
        end
        for (int i = 0; i < 4; i++) begin
            a = 2'(i);
            rd(a, rv);
            tests_run++;
            if (rv !== 32'd0) begin
                tests_failed++;
                $display("FAIL reset_read addr=%0d got=0x%08h exp=0x00000000", i, rv);
            end
        end
    endtask

    task automatic test_one_shot();
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        tick(1);
        for (int k = 2; k <= 6; k++) begin
            tick(1);
            rd(2'd2, rv);
            tests_run++;
            if (rv !== 32'(7 - k)) begin
                tests_failed++;
                $display("FAIL one_shot_count E%0d got=%0d exp=%0d", k, rv, 7 - k);
            end
            tests_run++;
            if (irq !== 1'b0) begin
                tests_failed++;
                $display("FAIL one_shot_irq_early E%0d got=%b exp=0", k, irq);
            end
        end
        tick(1);
        tests_run++;
        if (irq !== 1'b1) begin
            tests_failed++;
            $display("FAIL one_shot_irq_E7 got=%b exp=1", irq);
        end
        tick(1);
        rd(2'd0, rv);
        tests_run++;
        if (rv !== 32'h8) begin
            tests_failed++;
            $display("FAIL one_shot_ctrl got=0x%0h exp=0x8", rv);
        end
        tick(3);
        tests_run++;
        if (irq !== 1'b1) begin
            tests_failed++;
            $display("FAIL one_shot_sticky got=%b exp=1", irq);
        end
        int_ack = 1'b1;
        tick(1);
        int_ack = 1'b0;
        tests_run++;
        if (irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL one_shot_ack got=%b exp=0", irq);
        end
    endtask

    task automatic test_auto_reload();
        logic exp_irq;
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        for (int k = 1; k <= 22; k++) begin
            tick(1);
            exp_irq = ((k % 5) == 0);
            tests_run++;
            if (irq !== exp_irq) begin
                tests_failed++;
                $display("FAIL auto_reload_irq E%0d got=%b exp=%b", k, irq, exp_irq);
            end
        end
        wr(2'd0, 32'h0);
    endtask

    task automatic test_mask_abort();
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            tests_run++;
            if (irq !== 1'b0) begin
                tests_failed++;
                $display("FAIL masked_irq E%0d got=%b exp=0", k, irq);
            end
            if (k >= 4) begin
                tests_run++;
                if (dut.irq_flag_reg !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL masked_flag E%0d got=%b exp=1", k, dut.irq_flag_reg);
                end
            end
        end
        rd(2'd0, rv);
        tests_run++;
        if (rv !== 32'h0) begin
            tests_failed++;
            $display("FAIL masked_ctrl_en_clear got=0x%0h exp=0x0", rv);
        end

        // Abort mid-count: COUNT freezes at the value held when CTRL is written.
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h1);
        tick(4);
        rd(2'd2, rv);
        tests_run++;
        if (rv !== 32'd8) begin
            tests_failed++;
            $display("FAIL abort_count_before got=%0d exp=8", rv);
        end
        wr(2'd0, 32'h0);
        tick(5);
        rd(2'd2, rv);
        tests_run++;
        if (rv !== 32'd8) begin
            tests_failed++;
            $display("FAIL abort_count_frozen got=%0d exp=8", rv);
        end
        tests_run++;
        if (irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_irq got=%b exp=0", irq);
        end

        // PRESET rewrite while counting leaves the running COUNT alone.
        wr(2'd1, 32'd4);
        wr(2'd0, 32'h1);
        tick(3);
        wr(2'd1, 32'd9);
        rd(2'd2, rv);
        tests_run++;
        if (rv !== 32'd2) begin
            tests_failed++;
            $display("FAIL preset_rewrite_count got=%0d exp=2", rv);
        end
        tick(1);
        rd(2'd2, rv);
        tests_run++;
        if (rv !== 32'd1) begin
            tests_failed++;
            $display("FAIL preset_rewrite_count_next got=%0d exp=1", rv);
        end
        wr(2'd0, 32'h0);
    endtask

    task automatic test_boundaries();
        for (int p = 0; p <= 1; p++) begin
            wr(2'd1, 32'(p));
            wr(2'd0, 32'h9);
            tick(2);
            tests_run++;
            if (irq !== 1'b0) begin
                tests_failed++;
                $display("FAIL small_preset_early preset=%0d got=%b exp=0", p, irq);
            end
            tick(1);
            tests_run++;
            if (irq !== 1'b1) begin
                tests_failed++;
                $display("FAIL small_preset_E3 preset=%0d got=%b exp=1", p, irq);
            end
            wr(2'd0, 32'h0);
        end

        wr(2'd1, 32'hFFFF_FFFF);
        rd(2'd1, rv);
        tests_run++;
        if (rv !== 32'hFFFF_FFFF) begin
            tests_failed++;
            $display("FAIL max_preset_read got=0x%08h exp=0xffffffff", rv);
        end
        wr(2'd0, 32'h1);
        tick(2);
        rd(2'd2, rv);
        tests_run++;
        if (rv !== 32'hFFFF_FFFF) begin
            tests_failed++;
            $display("FAIL max_preset_load got=0x%08h exp=0xffffffff", rv);
        end
        tick(1);
        rd(2'd2, rv);
        tests_run++;
        if (rv !== 32'hFFFF_FFFE) begin
            tests_failed++;
            $display("FAIL max_preset_dec got=0x%08h exp=0xfffffffe", rv);
        end
        wr(2'd0, 32'h0);

        wr(2'd2, 32'h0000_1234);
        rd(2'd2, rv);
        tests_run++;
        if (rv !== 32'hFFFF_FFFE) begin
            tests_failed++;
            $display("FAIL count_write_ignored got=0x%08h exp=0xfffffffe", rv);
        end

        wr(2'd1, 32'd2);
        wr(2'd0, 32'h9);
        tick(3);
        int_ack = 1'b1;
        tick(1);
        int_ack = 1'b0;
        tests_run++;
        if (irq !== 1'b1) begin
            tests_failed++;
            $display("FAIL ack_on_entry got=%b exp=1", irq);
        end
        tick(1);
        tests_run++;
        if (irq !== 1'b1) begin
            tests_failed++;
            $display("FAIL ack_on_entry_sticky got=%b exp=1", irq);
        end
        int_ack = 1'b1;
        tick(1);
        int_ack = 1'b0;
        tests_run++;
        if (irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL ack_after_entry got=%b exp=0", irq);
        end
    endtask

    task automatic test_async_reset();
        int edges_before;
        logic [1:0] a;
        wr(2'd1, 32'd200);
        wr(2'd0, 32'h9);
        tick(102);
        rd(2'd2, rv);
        tests_run++;
        if (rv !== 32'd100) begin
            tests_failed++;
            $display("FAIL async_pre_count got=%0d exp=100", rv);
        end
        edges_before = edge_cnt;
        reset = 1'b0;
        #1;
        tests_run++;
        if (irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_irq got=%b exp=0", irq);
        end
        for (int i = 0; i < 4; i++) begin
            a = 2'(i);
            rd(a, rv);
            tests_run++;
            if (rv !== 32'd0) begin
                tests_failed++;
                $display("FAIL async_read addr=%0d got=0x%08h exp=0x00000000", i, rv);
            end
        end
        tests_run++;
        if (edge_cnt !== edges_before) begin
            tests_failed++;
            $display("FAIL async_no_edge got=%0d exp=%0d", edge_cnt, edges_before);
        end
        reset = 1'b1;
        tick(1);
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_mask_abort();
        test_boundaries();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/timer_int_source.md
# timer_int_source

Programmable countdown timer that generates one hardware-interrupt line into the coprocessor-0 interrupt logic; it is the source end of the `HWInt` interface. The CPU programs it through a 3-register word-addressed bus port. The CPU clears its sticky request with an acknowledge pulse issued after the interrupt is taken. One instance drives one `HWInt` bit; the system integrator chooses which bit.

## Interface
- No parameters.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `addr` input 2: word-select: 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = unmapped.
- `we` input 1: write strobe, sampled at rising edge.
- `wdata` input 32: write data.
- `rdata` output 32: combinational read of selected register; unmapped reads 0.
- `int_ack` input 1: one-cycle acknowledge; clears sticky request.
- `irq` output 1: interrupt request to one CP0 `HWInt` bit.

## Operation
- CTRL register, 32-bit:
  - bit0 EN.
  - bits2:1 MODE: 0 = one-shot; 1 = auto-reload; 2 and 3 behave as 0.
  - bit3 IM: interrupt mask, 1 = enabled.
  - bits31:4 read as 0; writes to them are ignored.
- PRESET is 32-bit and read/write. COUNT is 32-bit and read-only; writes to COUNT are ignored.
- `irq` = IM & irq_flag.
- FSM states: IDLE, LOAD, CNT, INT.
- IDLE:
  - EN = 1 → LOAD.
  - EN = 0 → stay in IDLE.
- LOAD: COUNT ← PRESET; → CNT.
- CNT:
  - EN = 0 → IDLE; COUNT holds its value.
  - COUNT > 1 → COUNT ← COUNT − 1.
  - COUNT ≤ 1 → COUNT ← 0, irq_flag ← 1, → INT.
- INT, MODE 0: EN ← 0; → IDLE. irq_flag stays set (sticky).
- INT, MODE 1: → LOAD; irq_flag ← 0 on leaving INT, giving a one-cycle pulse.
- Write to CTRL:
  - Loads bits3:0.
  - Clears irq_flag.
  - Forces the state to IDLE.
  - Overrides the FSM's own EN clear in the same cycle.
- Write to PRESET while counting: no effect on COUNT until the next LOAD.
- `int_ack` clears irq_flag.
  - Entering INT in the same cycle: the set wins.
  - A CTRL write in the same cycle also clears irq_flag.
- PRESET = 0 behaves identically to PRESET = 1 (one CNT cycle).
- COUNT never wraps below 0.

## Timing
- Reset values:
  - CTRL = 0, PRESET = 0, COUNT = 0.
  - State = IDLE, irq_flag = 0.
  - Therefore `irq` = 0 and `rdata` = 0 for every address.
- Register writes take effect at the sampling edge; `rdata` reflects the new value in the following cycle.
- Start latency, with CTRL written EN = 1 at edge E0 and PRESET = N ≥ 1:
  - LOAD at E1.
  - COUNT = N at E2.
  - COUNT = 1 at E(N+1).
  - INT and `irq` high after E(N+2).
- MODE 1 period: INT → LOAD → N CNT cycles, so `irq` pulses last 1 cycle every N+2 cycles.
- MODE 0: `irq` stays high until `int_ack`, a CTRL write, or reset; EN reads 0 from the cycle after INT.
- Reset assertion mid-count:
  - Immediately returns all state to reset values, without waiting for a clock edge.
  - Deassertion is synchronised by the integrator; the block requires no extra cycles.

## Test plan
- Reset: hold `reset` = 0, then release → `irq` = 0; reads of CTRL, PRESET, COUNT and addr 3 all return 0.
- One-shot:
  - Stimulus: PRESET = 5, then CTRL = 0x9 (EN, MODE 0, IM) at E0.
  - Required: COUNT reads 5, 4, 3, 2, 1; `irq` rises after E7 and stays high.
  - Required: CTRL reads 0x8.
  - Then `int_ack` → `irq` = 0 the next cycle.
- Auto-reload: PRESET = 3, CTRL = 0xB → `irq` one-cycle pulses exactly every 5 cycles for at least 4 periods.
- Mask and abort:
  - CTRL = 0x1 with PRESET = 2 → irq_flag sets internally but `irq` stays 0.
  - Write CTRL = 0x0 mid-count → state IDLE, COUNT frozen, no `irq`.
- Boundaries:
  - PRESET = 0 → INT after E3, same as PRESET = 1.
  - PRESET = 0xFFFFFFFF loads with no overflow.
  - `int_ack` in the same cycle as INT entry → `irq` still rises.
  - Write to COUNT is ignored.
- Async reset while in CNT with COUNT = 100 → all outputs 0 before the next clock edge.
